// File: rtl/ascon_wr_master.sv
// ascon_wr_master: drains ASCON result words into memory over Avalon-MM.
// Ports: iClk/iRst (sync, active-high); start_i + d_addr_i/out_gap_i/
// length_i job config; wr_info_* per-frame FIFO pop; res_* core result
// stream; o*/i*_Master_Write Avalon write master; busy_o, done_o status.
// Optional ASCON_WR_PERF_CNT_EN adds stall_cnt_o (waitrequest cycles).
module ascon_wr_master #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int TAG_WORDS  = 4,
  parameter int HASH_WORDS = 8
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [31:0]       out_gap_i,
  input  logic [31:0]       length_i,
  input  logic              wr_info_avail_i,
  input  logic [9:0]        wr_info_i,
  output logic              wr_info_req_o,
  input  logic [DATA_W-1:0] res_data_i,
  input  logic              res_vld_i,
  output logic              res_rdy_o,
  output logic [ADDR_W-1:0] oAddress_Master_Write,
  output logic              oWrite_Master_Write,
  output logic [DATA_W-1:0] oWriteData_Master_Write,
  output logic [3:0]        oByteEnable_Master_Write,
  input  logic              iWaitRequest_Master_Write,
  output logic              busy_o,
  output logic              done_o
`ifdef ASCON_WR_PERF_CNT_EN
  ,
  output logic [31:0]       stall_cnt_o
`endif
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CHECK = 3'd1;
  localparam logic [2:0] S_POP   = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_NEXT  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]        state;
  logic [31:0]       gap_q;
  logic [31:0]       len_q;
  logic [31:0]       frame_cnt;
  logic [ADDR_W-1:0] frame_base;
  logic [8:0]        word_total;
  logic [8:0]        words_taken;
  logic [8:0]        word_calc;
  logic              dec_f;
  logic              hash_f;
  logic [7:0]        ad_w;
  logic              accept;
  logic              wr_done;

  assign dec_f  = wr_info_i[9];
  assign hash_f = wr_info_i[8];
  assign ad_w   = wr_info_i[7:0];

  always_comb begin
    word_calc = '0;
    unique case (1'b1)
      hash_f:
        word_calc = 9'(HASH_WORDS);
      (!hash_f && dec_f):
        word_calc = {1'b0, ad_w} + 9'd1;
      (!hash_f && !dec_f):
        word_calc = {1'b0, ad_w} + 9'(TAG_WORDS);
      default:
        word_calc = '0;
    endcase
  end

  assign wr_done = oWrite_Master_Write
                 & ~iWaitRequest_Master_Write;

  // Output register can reload in the cycle its current write retires.
  assign res_rdy_o = (state == S_WRITE)
                   & (words_taken < word_total)
                   & (~oWrite_Master_Write
                      | ~iWaitRequest_Master_Write);

  assign accept        = res_vld_i & res_rdy_o;
  assign wr_info_req_o = (state == S_POP);
  assign busy_o        = (state != S_IDLE);
  assign done_o        = (state == S_DONE);
  assign oByteEnable_Master_Write = 4'hF;

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state                   <= S_IDLE;
      gap_q                   <= '0;
      len_q                   <= '0;
      frame_cnt               <= '0;
      frame_base              <= '0;
      word_total              <= '0;
      words_taken             <= '0;
      oWrite_Master_Write     <= 1'b0;
      oAddress_Master_Write   <= '0;
      oWriteData_Master_Write <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start_i) begin
            gap_q      <= out_gap_i;
            len_q      <= length_i;
            frame_cnt  <= '0;
            frame_base <= d_addr_i;
            state      <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (frame_cnt == len_q)
            state <= S_DONE;
          else if (wr_info_avail_i)
            state <= S_POP;
        end
        S_POP: begin
          word_total  <= word_calc;
          words_taken <= '0;
          state       <= S_WRITE;
        end
        S_WRITE: begin
          // All words taken: frame ends when the last one retires.
          if (words_taken == word_total && wr_done)
            state <= S_NEXT;
        end
        S_NEXT: begin
          frame_cnt  <= frame_cnt + 32'd1;
          frame_base <= frame_base + ADDR_W'(gap_q);
          state      <= S_CHECK;
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase

      if (accept) begin
        oWrite_Master_Write     <= 1'b1;
        oWriteData_Master_Write <= res_data_i;
        oAddress_Master_Write   <= frame_base
          + ADDR_W'({words_taken, 2'b00});
        words_taken             <= words_taken + 9'd1;
      end else if (wr_done) begin
        oWrite_Master_Write <= 1'b0;
      end
    end
  end

`ifdef ASCON_WR_PERF_CNT_EN
  always_ff @(posedge iClk) begin
    if (iRst)
      stall_cnt_o <= '0;
    else if (state == S_IDLE && start_i)
      stall_cnt_o <= '0;
    else if (oWrite_Master_Write
             && iWaitRequest_Master_Write
             && stall_cnt_o != 32'hFFFF_FFFF)
      stall_cnt_o <= stall_cnt_o + 32'd1;
  end
`endif

endmodule

// File: tb/tb_ascon_wr_master.sv
// tb_ascon_wr_master: directed + randomized jobs against a
// frame/word-list reference model of the write-back master.
module tb_ascon_wr_master;

  logic        iClk = 1'b0;
  logic        iRst;
  logic        start_i;
  logic [31:0] d_addr_i;
  logic [31:0] out_gap_i;
  logic [31:0] length_i;
  logic        wr_info_avail_i;
  logic [9:0]  wr_info_i;
  logic        wr_info_req_o;
  logic [31:0] res_data_i;
  logic        res_vld_i;
  logic        res_rdy_o;
  logic [31:0] oAddr;
  logic        oWrite;
  logic [31:0] oData;
  logic [3:0]  oBe;
  logic        iWait;
  logic        busy_o;
  logic        done_o;
`ifdef ASCON_WR_PERF_CNT_EN
  logic [31:0] stall_cnt_o;
`endif

  always #5 iClk = ~iClk;

  ascon_wr_master dut (
    .iClk                      (iClk),
    .iRst                      (iRst),
    .start_i                   (start_i),
    .d_addr_i                  (d_addr_i),
    .out_gap_i                 (out_gap_i),
    .length_i                  (length_i),
    .wr_info_avail_i           (wr_info_avail_i),
    .wr_info_i                 (wr_info_i),
    .wr_info_req_o             (wr_info_req_o),
    .res_data_i                (res_data_i),
    .res_vld_i                 (res_vld_i),
    .res_rdy_o                 (res_rdy_o),
    .oAddress_Master_Write     (oAddr),
    .oWrite_Master_Write       (oWrite),
    .oWriteData_Master_Write   (oData),
    .oByteEnable_Master_Write  (oBe),
    .iWaitRequest_Master_Write (iWait),
    .busy_o                    (busy_o),
    .done_o                    (done_o)
`ifdef ASCON_WR_PERF_CNT_EN
    ,
    .stall_cnt_o               (stall_cnt_o)
`endif
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    int          f;
  } wr_t;

  wr_t         exp_q[$];
  logic [31:0] core_q[$];
  logic [9:0]  info_q[$];

  int n_cmp = 0;
  int n_err = 0;

  localparam int M_NONE  = 0;
  localparam int M_TPUT  = 1;
  localparam int M_STALL = 2;
  localparam int M_EMPTY = 3;
  localparam int M_BUSY  = 4;
  localparam int M_ABORT = 5;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  function automatic int words_of(input logic [9:0] info);
    if (info[8]) return 8;
    if (info[9]) return int'(info[7:0]) + 1;
    return int'(info[7:0]) + 4;
  endfunction

  task automatic idle_inputs();
    start_i         = 1'b0;
    res_vld_i       = 1'b0;
    iWait           = 1'b0;
    wr_info_avail_i = 1'b0;
  endtask

  task automatic run_job(input logic [31:0] base,
                         input logic [31:0] gap,
                         input int len,
                         input int wp,
                         input int vp,
                         input int ap,
                         input int mode,
                         input int abort_at);
    int nwr = 0;
    int npop = 0;
    int nstall = 0;
    int ndone = 0;
    int extra = 0;
    int last_cyc = -10;
    int last_f = -1;
    int avail_on = -1;
    int first_pop = -1;
    int stall_used = 0;
    bit held = 0;
    bit finished = 0;
    bit aborted = 0;
    logic [31:0] h_a = '0;
    logic [31:0] h_d = '0;
    logic [31:0] fb = base;
    logic [31:0] d;
    logic [31:0] tmp;
    logic [9:0]  itmp;
    exp_q.delete();
    core_q.delete();
    for (int f = 0; f < len; f++) begin
      for (int i = 0; i < words_of(info_q[f]); i++) begin
        d = $urandom;
        exp_q.push_back('{a: fb + 32'(4 * i),
                          d: d, f: f});
        core_q.push_back(d);
      end
      fb = fb + gap;
    end
    for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
      @(negedge iClk);
      start_i   = (cyc == 0)
               || (mode == M_BUSY && cyc == 1);
      d_addr_i  = (cyc == 0) ? base : $urandom;
      out_gap_i = (cyc == 0) ? gap : $urandom;
      length_i  = (cyc == 0) ? 32'(len)
                : 32'($urandom_range(1, 9));
      if (mode == M_STALL)
        iWait = oWrite && nwr == 1 && stall_used < 3;
      else
        iWait = ($urandom_range(0, 99) < wp);
      if (mode == M_STALL && iWait) stall_used++;
      res_vld_i  = core_q.size() > 0
                && $urandom_range(0, 99) < vp;
      res_data_i = core_q.size() > 0
                 ? core_q[0] : $urandom;
      wr_info_avail_i = info_q.size() > 0
        && (mode == M_EMPTY ? cyc >= 10
            : $urandom_range(0, 99) < ap);
      if (mode == M_EMPTY && wr_info_avail_i
          && avail_on < 0)
        avail_on = cyc;
      wr_info_i = info_q.size() > 0
                ? info_q[0] : 10'($urandom);
      #1;
      if (cyc >= 1) chk("busy", busy_o, 1);
      if (held) begin
        chk("hold_write", oWrite, 1);
        chk("hold_addr", oAddr, h_a);
        chk("hold_data", oData, h_d);
      end
      held = oWrite && iWait;
      if (held) begin
        h_a = oAddr;
        h_d = oData;
        nstall++;
        chk("rdy_in_stall", res_rdy_o, 0);
      end
      if (oWrite && !iWait) begin
        if (exp_q.size() == 0) extra++;
        else begin
          chk("wr_addr", oAddr, exp_q[0].a);
          chk("wr_data", oData, exp_q[0].d);
          if (mode == M_TPUT && exp_q[0].f == last_f)
            chk("tput_gap", cyc - last_cyc, 1);
          last_f   = exp_q[0].f;
          last_cyc = cyc;
          tmp = exp_q[0].d;
          exp_q.pop_front();
          nwr++;
        end
      end
      if (res_vld_i && res_rdy_o)
        tmp = core_q.pop_front();
      if (wr_info_req_o) begin
        if (info_q.size() > 0) itmp = info_q.pop_front();
        else extra++;
        npop++;
        if (first_pop < 0) first_pop = cyc;
      end
      if (mode == M_ABORT && nwr == abort_at) begin
        @(negedge iClk);
        idle_inputs();
        iRst = 1'b1;
        @(negedge iClk);
        #1;
        chk("abort_write", oWrite, 0);
        chk("abort_busy", busy_o, 0);
        chk("abort_rdy", res_rdy_o, 0);
`ifdef ASCON_WR_PERF_CNT_EN
        chk("abort_stall_cnt", stall_cnt_o, 0);
`endif
        iRst = 1'b0;
        info_q.delete();
        finished = 1;
        aborted = 1;
      end else if (done_o) begin
        ndone++;
        finished = 1;
        if (len == 0) chk("len0_done_lat", cyc, 2);
        if (mode == M_EMPTY)
          chk("pop_after_avail", first_pop, avail_on + 1);
        if (mode == M_STALL) chk("stall_cycles", nstall, 3);
        chk("left_writes", exp_q.size(), 0);
        chk("pops", npop, len);
        chk("extra", extra, 0);
`ifdef ASCON_WR_PERF_CNT_EN
        chk("stall_cnt", stall_cnt_o, nstall);
`endif
      end
    end
    if (!aborted) begin
      chk("done_count", ndone, 1);
      @(negedge iClk);
      idle_inputs();
      #1;
      chk("post_done", done_o, 0);
      chk("post_busy", busy_o, 0);
`ifdef ASCON_WR_PERF_CNT_EN
      chk("stall_hold", stall_cnt_o, nstall);
`endif
    end
  endtask

  initial begin
    int len;
    iRst       = 1'b1;
    d_addr_i   = '0;
    out_gap_i  = '0;
    length_i   = '0;
    wr_info_i  = '0;
    res_data_i = '0;
    idle_inputs();
    repeat (3) @(negedge iClk);
    #1;
    chk("rst_write", oWrite, 0);
    chk("rst_addr", oAddr, 0);
    chk("rst_data", oData, 0);
    chk("rst_be", oBe, 4'hF);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_req", wr_info_req_o, 0);
    chk("rst_rdy", res_rdy_o, 0);
`ifdef ASCON_WR_PERF_CNT_EN
    chk("rst_stall_cnt", stall_cnt_o, 0);
`endif
    iRst = 1'b0;

    info_q = '{10'h003};
    run_job(32'h1000, 32'h100, 1,
            0, 100, 100, M_TPUT, 0);

    info_q = '{10'h202, 10'h105};
    run_job(32'h2000, 32'h40, 2,
            0, 100, 100, M_BUSY, 0);

    info_q = '{10'h003};
    run_job(32'h3000, 32'h0, 1,
            0, 100, 100, M_STALL, 0);

    info_q.delete();
    run_job(32'h4000, 32'h10, 0,
            0, 100, 100, M_BUSY, 0);

    info_q = '{10'h001};
    run_job(32'h5000, 32'h20, 1,
            0, 100, 100, M_EMPTY, 0);

    info_q = '{10'h00A};
    run_job(32'h6000, 32'h20, 1,
            0, 100, 100, M_ABORT, 3);

    info_q = '{10'h004, 10'h300};
    run_job(32'h7000, 32'h80, 2,
            20, 80, 70, M_NONE, 0);

    info_q = '{10'h002, 10'h001};
    run_job(32'hFFFF_FFF0, 32'h10, 2,
            0, 100, 100, M_TPUT, 0);

    repeat (4) begin
      len = $urandom_range(1, 3);
      info_q.delete();
      for (int i = 0; i < len; i++)
        info_q.push_back({2'($urandom),
                          8'($urandom_range(0, 10))});
      run_job($urandom & 32'hFFFF_FFFC,
              32'($urandom_range(0, 64) * 4), len,
              $urandom_range(0, 50),
              $urandom_range(40, 100),
              $urandom_range(20, 100),
              M_NONE, 0);
    end

    for (int i = 0; i < 4; i++) begin
      @(negedge iClk);
      idle_inputs();
      res_vld_i  = 1'b1;
      res_data_i = $urandom;
      #1;
      chk("idle_rdy", res_rdy_o, 0);
      chk("idle_write", oWrite, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ascon_wr_master.md
Name: ascon_wr_master

Overview:
- Write-back end of the DMA/ASCON path; consumes the per-frame write-info FIFO (`wr_info_avail`/`wr_info_req`/`wr_info`) filled by the control register file.
- Drains ASCON result words from the core and writes them to memory over the Avalon-MM master-write interface.
- Addressing: destination `d_addr`, per-frame stride `out_gap`, frame count `length`.
- Raises `done_o` when all frames are written.

Parameters:
- ADDR_W, 32, Avalon address width (byte addressing, word step 4).
- DATA_W, 32, data word width.
- TAG_WORDS, 4, tag words appended in encrypt mode.
- HASH_WORDS, 8, digest words written in hash mode.

Ports:
- iClk  in  1  clock
- iRst  in  1  reset, synchronous, active-high
- start_i  in  1  single-cycle job start; latches `d_addr_i`, `out_gap_i`, `length_i`
- d_addr_i  in  ADDR_W  destination base address
- out_gap_i  in  32  byte stride between frame bases
- length_i  in  32  number of frames
- wr_info_avail_i  in  1  write-info FIFO not empty
- wr_info_i  in  10  {dec_flag, hash_flag, ad_words[7:0]}, FIFO show-ahead output
- wr_info_req_o  out  1  FIFO pop, one cycle
- res_data_i  in  DATA_W  result word from ASCON core
- res_vld_i  in  1  result word valid
- res_rdy_o  out  1  result word accepted when `res_vld_i & res_rdy_o`
- oAddress_Master_Write  out  ADDR_W  write address
- oWrite_Master_Write  out  1  write request
- oWriteData_Master_Write  out  DATA_W  write data
- oByteEnable_Master_Write  out  4  always 4'hF
- iWaitRequest_Master_Write  in  1  slave stall
- busy_o  out  1  job in progress
- done_o  out  1  one-cycle pulse at job end

Behaviour:
- Reset (iRst=1 at posedge): state IDLE; all outputs 0 except `oByteEnable`=4'hF; counters cleared.
- Reset mid-job: the job is abandoned, any pending write is dropped and the block returns to IDLE.
- FSM:
  - IDLE: on `start_i`, latch config, frame_cnt=0, frame_base=d_addr. Go to CHECK.
  - CHECK: if frame_cnt==length, go to DONE. Else if `wr_info_avail_i`, go to POP. Else stay.
  - POP: assert `wr_info_req_o` for 1 cycle; latch `wr_info_i`; compute word_total; go to WRITE.
  - word_total rules:
    - hash_flag=1: HASH_WORDS; ad_words and dec_flag are ignored.
    - dec_flag=1: ad_words+1 (one verify-status word).
    - otherwise: ad_words+TAG_WORDS.
    - Arithmetic is 9-bit and unsigned; no overflow is possible.
  - WRITE: stream word_total result words; addr = frame_base + 4*word_idx. When the last write is accepted, go to NEXT.
  - NEXT: frame_cnt++, frame_base += out_gap (wraps mod 2^ADDR_W); go to CHECK.
  - DONE: pulse `done_o`; go to IDLE.
- `busy_o`=1 in every state except IDLE.
- `start_i` while busy is ignored.
- length=0: `done_o` pulses exactly 2 cycles after start (IDLE→CHECK→DONE); no pops, no writes.
- Write handshake (single-entry output register):
  - `res_rdy_o` = in WRITE & words_taken<word_total & (~oWrite | ~iWaitRequest).
  - An accepted word appears on `oWrite`/`oWriteData`/`oAddress` the next cycle (latency 1).
  - `oWrite` and address/data hold stable while `iWaitRequest`=1.
  - A new word may load in the same cycle the previous write completes, giving full throughput of 1 word/cycle with no waitrequest.
- `res_vld_i` is never accepted outside WRITE; extra words stay in the core.
- FIFO empty in CHECK stalls indefinitely; no timeout.

Optional Feature:
- Macro ASCON_WR_PERF_CNT_EN.
- Defined: adds output `stall_cnt_o[31:0]`.
  - Counts cycles with `oWrite_Master_Write & iWaitRequest_Master_Write` during the job.
  - Cleared on `start_i` accepted in IDLE and on reset.
  - Saturates at 32'hFFFFFFFF.
  - Holds its value after `done_o`.
- Undefined: no port, no counter logic.

Test Plan:
- Encrypt, 1 frame: start d_addr=0x1000, gap=0x100, length=1; wr_info={0,0,8'd3}; core supplies 7 words, no stall → 7 writes at 0x1000..0x1018 on consecutive cycles, 1 pop, `done_o` 1 pulse.
- Decrypt + hash, 2 frames, gap=0x40: frame0 wr_info={1,0,8'd2} → 3 writes at 0x2000..0x2008; frame1 wr_info={0,1,8'd5} → 8 writes at 0x2040..0x205C.
- Waitrequest: assert `iWaitRequest` 3 cycles on 2nd write → address/data stable for 4 cycles, `res_rdy_o`=0 meanwhile, no word lost or duplicated; with macro, stall_cnt_o=3.
- length=0 → no `wr_info_req_o`, no `oWrite`, `done_o` 2 cycles after start; start during busy → ignored.
- FIFO empty for 10 cycles in CHECK → no pop, no writes. Then avail=1 → pop next cycle, writes proceed.
- iRst asserted mid-WRITE → next cycle `oWrite`=0, `busy_o`=0, IDLE. A new start then runs a clean job from frame 0.
